// File: rtl/adc128s_spi_model_if.sv
// SPI pin bundle between the Segway A2D master and the ADC128S-style converter model.
interface adc128s_spi_model_if;
  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (output SS_n, output SCLK, output MOSI, input MISO);
  modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/adc128s_spi_model.sv
// 8-channel 12-bit SPI A/D model: oversampled mode-0 slave that returns the sample chosen by the previous frame.
// Pins are seen 3 clk after they move; the master must hold each SCLK phase for at least 4 clk.
module adc128s_spi_model (
  input  logic                      clk,
  input  logic                      rst_n,
  adc128s_spi_model_if.slave        spi,
  input  logic               [11:0] lft_ld,
  input  logic               [11:0] rght_ld,
  input  logic               [11:0] batt
);

  logic [2:0]  ss_q;
  logic [2:0]  sclk_q;
  logic [1:0]  mosi_q;
  logic [15:0] tx_shift_q, tx_shift_d;
  // Only bits [13:11] of the 16-bit command matter, so the MSB that has shifted out is not kept.
  logic [14:0] rx_shift_q, rx_shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  channel_q, channel_d;
  logic [11:0] result_q, result_d;
  logic [11:0] mux_val;

  logic ss_fall, ss_rise, ss_active, sclk_rise, sclk_fall;

  assign ss_fall   =  ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] &  ss_q[1];
  assign ss_active = ~ss_q[1];
  assign sclk_rise = ~sclk_q[2] &  sclk_q[1];
  assign sclk_fall =  sclk_q[2] & ~sclk_q[1];

  // Drive only once the frame has actually started, so the loaded word is what appears first.
  assign spi.MISO = ss_q[2] ? 1'bz : tx_shift_q[15];

  always_comb begin
    unique case (rx_shift_q[13:11])
      3'd0:    mux_val = lft_ld;
      3'd4:    mux_val = rght_ld;
      3'd5:    mux_val = batt;
      default: mux_val = 12'h000;
    endcase
  end

  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    channel_d  = channel_q;
    result_d   = result_q;
    if (ss_fall) begin
      tx_shift_d = {4'h0, result_q};
      bit_cnt_d  = 5'd0;
    end else if (ss_rise) begin
      if (bit_cnt_q == 5'd16) begin
        channel_d = rx_shift_q[13:11];
        result_d  = mux_val;
      end
    end else if (ss_active) begin
      if (sclk_rise) begin
        rx_shift_d = {rx_shift_q[13:0], mosi_q[1]};
        if (bit_cnt_q != 5'd16) bit_cnt_d = bit_cnt_q + 5'd1;
      end
      if (sclk_fall && (bit_cnt_q != 5'd0)) tx_shift_d = {tx_shift_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q       <= 3'b111;
      sclk_q     <= 3'b000;
      mosi_q     <= 2'b00;
      tx_shift_q <= 16'h0000;
      rx_shift_q <= 15'h0000;
      bit_cnt_q  <= 5'd0;
      channel_q  <= 3'd0;
      result_q   <= 12'h000;
    end else begin
      ss_q       <= {ss_q[1:0], spi.SS_n};
      sclk_q     <= {sclk_q[1:0], spi.SCLK};
      mosi_q     <= {mosi_q[0], spi.MOSI};
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      channel_q  <= channel_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Directed bench for adc128s_spi_model: plays an SPI master and checks each returned word against hand-computed values.
module tb_adc128s_spi_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] lft_ld, rght_ld, batt;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [15:0] rx;

  adc128s_spi_model_if spi();

  adc128s_spi_model dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spi     (spi),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One mode-0 frame of nbits clocks; batt switches to 12'h100 just before bit chg_bit when chg_bit >= 0.
  task automatic frame(input logic [15:0] cmd, input int nbits, input int chg_bit, output logic [15:0] word);
    word = 16'h0000;
    spi.SS_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) batt = 12'h100;
      spi.MOSI = cmd[15-i];
      word = {word[14:0], spi.MISO};
      spi.SCLK = 1'b1;
      wait_clks(6);
      spi.SCLK = 1'b0;
      wait_clks(6);
    end
    spi.SS_n = 1'b1;
    spi.MOSI = 1'b0;
    wait_clks(8);
  endtask

  initial begin
    rst_n    = 1'b0;
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    lft_ld   = 12'hABC;
    rght_ld  = 12'h123;
    batt     = 12'hFED;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);

    check("reset_result", {4'h0, dut.result_q}, 16'h0000);
    check("reset_channel", {13'h0, dut.channel_q}, 16'h0000);

    frame(16'h0000, 16, -1, rx);
    check("first_frame", rx, 16'h0000);
    frame(16'h2000, 16, -1, rx);
    check("ch0_lft", rx, 16'h0ABC);
    check("channel_4", {13'h0, dut.channel_q}, 16'h0004);

    // SCLK toggling while deselected must not disturb anything.
    for (int i = 0; i < 5; i++) begin
      spi.SCLK = 1'b1; spi.MOSI = 1'b1; wait_clks(6);
      spi.SCLK = 1'b0; wait_clks(6);
    end
    spi.MOSI = 1'b0;
    check("idle_sclk_result", {4'h0, dut.result_q}, 16'h0123);

    frame(16'h2800, 16, -1, rx);
    check("ch4_rght", rx, 16'h0123);

    lft_ld = 12'hFFF; rght_ld = 12'hFFF; batt = 12'hFFF;
    frame(16'h1800, 16, -1, rx);
    check("ch5_batt", rx, 16'h0FED);
    check("channel_3", {13'h0, dut.channel_q}, 16'h0003);

    batt = 12'h800;
    frame(16'h2800, 16, -1, rx);
    check("ch3_zero", rx, 16'h0000);
    check("channel_5", {13'h0, dut.channel_q}, 16'h0005);

    frame(16'h2800, 16, 6, rx);
    check("batt_midframe", rx, 16'h0800);

    lft_ld = 12'hABC;
    frame(16'h0000, 16, -1, rx);
    check("batt_new", rx, 16'h0100);

    frame(16'h2000, 8, -1, rx);
    check("runt_channel", {13'h0, dut.channel_q}, 16'h0000);
    check("runt_result", {4'h0, dut.result_q}, 16'h0ABC);
    frame(16'h2000, 16, -1, rx);
    check("after_runt", rx, 16'h0ABC);
    check("ch4_latched", {4'h0, dut.result_q}, 16'h0FFF);

    // Start a frame, then reset partway through it.
    spi.SS_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < 5; i++) begin
      spi.SCLK = 1'b1; wait_clks(6);
      spi.SCLK = 1'b0; wait_clks(6);
    end
    rst_n = 1'b0;
    wait_clks(2);
    spi.SS_n = 1'b1;
    rst_n = 1'b1;
    wait_clks(8);
    check("midreset_result", {4'h0, dut.result_q}, 16'h0000);
    frame(16'h2000, 16, -1, rx);
    check("after_reset", rx, 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
